mio_bus_ctrl: RTL and testbench

MIO_BUS_CTRL -- requirements
Module: mio_bus_ctrl

---
 rtl/mio_pkg.sv | 23 ++
 rtl/mio_irq_ctrl.sv | 69 ++++++
 rtl/mio_bus_ctrl.sv | 156 +++++++++++++++
 tb/tb_mio_bus_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mio_pkg.sv
// Shared types and constants for the memory-mapped I/O bus controller.
package mio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic [3:0]  REG_REGION       = 4'hF;
  localparam logic [27:0] OFF_MASK         = 28'h000_0000;
  localparam logic [27:0] OFF_PEND         = 28'h000_0004;
  localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

  // CPU request captured when a transaction is accepted
  typedef struct packed {
    logic        we;
    logic [3:0]  region;
    logic [27:0] addr;
    logic [31:0] wdata;
  } mio_req_t;

endpackage

// File: rtl/mio_irq_ctrl.sv
// Interrupt block: slave IRQ edge detection, pending/mask registers,
// registered interrupt request and lowest-index priority encoding.
module mio_irq_ctrl
  import mio_pkg::*;
#(
  parameter int unsigned NCH = 4
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [NCH-1:0] slv_irq,
  input  logic           mask_we,
  input  logic           pend_clr,
  input  logic [NCH-1:0] wdata,
  output logic           INT,
  output logic [3:0]     int_id,
  output logic [NCH-1:0] pending,
  output logic [NCH-1:0] irq_mask
);

  logic [NCH-1:0] irq_prev_q;
  logic [NCH-1:0] pend_q;
  logic [NCH-1:0] mask_q;
  logic           int_q;
  logic [3:0]     id_q;

  logic [NCH-1:0] rise_c;
  logic [NCH-1:0] clr_c;
  logic [NCH-1:0] active_c;
  logic [3:0]     id_c;

  assign rise_c   = slv_irq & ~irq_prev_q;
  assign clr_c    = pend_clr ? wdata : '0;
  assign active_c = pend_q & mask_q;

  // Scan from the top so the lowest active index is the last one written
  always_comb begin
    id_c = 4'd0;
    for (int k = NCH - 1; k >= 0; k--) begin
      if (active_c[k]) begin
        id_c = 4'(k);
      end
    end
  end

  // A new edge beats a same-cycle write-1-to-clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_prev_q <= '0;
      pend_q     <= '0;
      mask_q     <= '0;
      int_q      <= 1'b0;
      id_q       <= 4'd0;
    end else begin
      irq_prev_q <= slv_irq;
      pend_q     <= (pend_q & ~clr_c) | rise_c;
      if (mask_we) begin
        mask_q <= wdata;
      end
      int_q      <= |active_c;
      id_q       <= id_c;
    end
  end

  assign INT      = int_q;
  assign int_id   = id_q;
  assign pending  = pend_q;
  assign irq_mask = mask_q;

endmodule

// File: rtl/mio_bus_ctrl.sv
// CPU-to-slave bus bridge: decodes the address region, runs a fixed-wait
// slave access, serves the internal interrupt registers and flags bad regions.
module mio_bus_ctrl
  import mio_pkg::*;
#(
  parameter int unsigned NCH      = 4,
  parameter int unsigned WAIT     = 2,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              CPU_MIO,
  input  logic              mem_w,
  input  logic [31:0]       Addr_in,
  input  logic [31:0]       Data_in,
  output logic [31:0]       Data_out,
  output logic              MIO_ready,
  output logic              INT,
  output logic [3:0]        int_id,
  output logic              bus_err,
  output logic [NCH-1:0]    slv_sel,
  output logic              slv_we,
  output logic [27:0]       slv_addr,
  output logic [31:0]       slv_wdata,
  input  logic [NCH*32-1:0] slv_rdata,
  input  logic [NCH-1:0]    slv_irq
);

  localparam logic [3:0] NCH_R  = 4'(NCH);
  localparam logic [3:0] WAIT_R = 4'(WAIT);

  state_t         state_q;
  mio_req_t       req_q;
  logic [3:0]     cnt_q;
  logic [NCH-1:0] sel_q;
  logic           we_q;
  logic [31:0]    dout_q;
  logic           ready_q;
  logic           err_q;

  logic           mapped_c;
  logic           is_reg_c;
  logic           last_c;
  logic           reg_wr_c;
  logic           mask_we_c;
  logic           pend_clr_c;
  logic [31:0]    rdata_c;
  logic [NCH-1:0] pending;
  logic [NCH-1:0] irq_mask;

  assign mapped_c   = req_q.region < NCH_R;
  assign is_reg_c   = req_q.region == REG_REGION;
  assign last_c     = !mapped_c || (cnt_q == WAIT_R);
  assign reg_wr_c   = (state_q == ST_ACCESS) && is_reg_c && req_q.we;
  assign mask_we_c  = reg_wr_c && (req_q.addr == OFF_MASK);
  assign pend_clr_c = reg_wr_c && (req_q.addr == OFF_PEND);

  // Read data source for the region latched with the request
  always_comb begin
    rdata_c = ERR_DATA;
    if (mapped_c) begin
      for (int k = 0; k < NCH; k++) begin
        if (req_q.region == 4'(k)) begin
          rdata_c = slv_rdata[k*32 +: 32];
        end
      end
    end else if (is_reg_c) begin
      if (req_q.addr == OFF_MASK) begin
        rdata_c = 32'(irq_mask);
      end else if (req_q.addr == OFF_PEND) begin
        rdata_c = 32'(pending);
      end else begin
        rdata_c = 32'h0;
      end
    end
  end

  // Transaction FSM with registered bus and CPU-side outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      req_q   <= '0;
      cnt_q   <= 4'd0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      dout_q  <= 32'h0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          ready_q <= 1'b0;
          if (CPU_MIO) begin
            req_q.we     <= mem_w;
            req_q.region <= Addr_in[31:28];
            req_q.addr   <= Addr_in[27:0];
            req_q.wdata  <= Data_in;
            cnt_q        <= 4'd0;
            state_q      <= ST_ACCESS;
            if (Addr_in[31:28] < NCH_R) begin
              sel_q <= NCH'(1) << Addr_in[31:28];
              we_q  <= mem_w;
            end
          end
        end
        ST_ACCESS: begin
          if (last_c) begin
            sel_q   <= '0;
            we_q    <= 1'b0;
            ready_q <= 1'b1;
            state_q <= ST_DONE;
            if (!req_q.we) begin
              dout_q <= rdata_c;
            end
            if (!mapped_c && !is_reg_c) begin
              err_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        ST_DONE: begin
          ready_q <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  mio_irq_ctrl #(
    .NCH (NCH)
  ) u_irq (
    .clk      (clk),
    .reset    (reset),
    .slv_irq  (slv_irq),
    .mask_we  (mask_we_c),
    .pend_clr (pend_clr_c),
    .wdata    (req_q.wdata[NCH-1:0]),
    .INT      (INT),
    .int_id   (int_id),
    .pending  (pending),
    .irq_mask (irq_mask)
  );

  assign Data_out  = dout_q;
  assign MIO_ready = ready_q;
  assign bus_err   = err_q;
  assign slv_sel   = sel_q;
  assign slv_we    = we_q;
  assign slv_addr  = req_q.addr;
  assign slv_wdata = req_q.wdata;

endmodule

// File: tb/tb_mio_bus_ctrl.sv
// Self-checking bench for mio_bus_ctrl against a transaction-level model.
module tb_mio_bus_ctrl;

  localparam int unsigned NCH  = 4;
  localparam int unsigned WAIT = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              CPU_MIO;
  logic              mem_w;
  logic [31:0]       Addr_in;
  logic [31:0]       Data_in;
  logic [31:0]       Data_out;
  logic              MIO_ready;
  logic              INT;
  logic [3:0]        int_id;
  logic              bus_err;
  logic [NCH-1:0]    slv_sel;
  logic              slv_we;
  logic [27:0]       slv_addr;
  logic [31:0]       slv_wdata;
  logic [NCH*32-1:0] slv_rdata;
  logic [NCH-1:0]    slv_irq;

  int checks   = 0;
  int failures = 0;

  logic [NCH-1:0] m_mask;
  logic [NCH-1:0] m_pend;
  logic [NCH-1:0] m_irq_prev;
  logic [31:0]    m_dout;
  logic           m_err;

  always #5 clk = ~clk;

  mio_bus_ctrl #(
    .NCH  (NCH),
    .WAIT (WAIT)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .CPU_MIO   (CPU_MIO),
    .mem_w     (mem_w),
    .Addr_in   (Addr_in),
    .Data_in   (Data_in),
    .Data_out  (Data_out),
    .MIO_ready (MIO_ready),
    .INT       (INT),
    .int_id    (int_id),
    .bus_err   (bus_err),
    .slv_sel   (slv_sel),
    .slv_we    (slv_we),
    .slv_addr  (slv_addr),
    .slv_wdata (slv_wdata),
    .slv_rdata (slv_rdata),
    .slv_irq   (slv_irq)
  );

  function automatic logic [3:0] exp_id(input logic [NCH-1:0] act);
    logic [3:0] id;
    logic       found;
    id    = 4'd0;
    found = 1'b0;
    for (int k = 0; k < NCH; k++) begin
      if (act[k] && !found) begin
        id    = 4'(k);
        found = 1'b1;
      end
    end
    return id;
  endfunction

  task automatic model_reset();
    m_mask     = '0;
    m_pend     = '0;
    m_irq_prev = '0;
    m_dout     = 32'h0;
    m_err      = 1'b0;
  endtask

  task automatic drive_irq(input logic [NCH-1:0] v);
    m_pend     = m_pend | (v & ~m_irq_prev);
    m_irq_prev = v;
    slv_irq    = v;
  endtask

  // Full transaction; called and returns at a negedge in an idle cycle
  task automatic txn(input string name, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [NCH-1:0] irq_v);
    logic [3:0]     region;
    logic [NCH-1:0] exp_onehot;
    logic [31:0]    exp_rd;
    int             exp_lat, exp_sel, exp_we, lat, sel_cyc, we_cyc, bad_sel;
    logic           mapped;
    region = addr[31:28];
    mapped = region < NCH;
    if (mapped) begin
      exp_lat    = WAIT + 3;
      exp_sel    = WAIT + 1;
      exp_onehot = NCH'(1) << region;
      exp_rd     = slv_rdata[region*32 +: 32];
    end else begin
      exp_lat    = 3;
      exp_sel    = 0;
      exp_onehot = '0;
      if (region == 4'hF) begin
        exp_rd = (addr[27:0] == 28'h0) ? 32'(m_mask) :
                 (addr[27:0] == 28'h4) ? 32'(m_pend) : 32'h0;
      end else begin
        exp_rd = 32'hDEAD_BEEF;
      end
    end
    exp_we = (we && mapped) ? WAIT + 1 : 0;

    CPU_MIO = 1'b1;
    mem_w   = we;
    Addr_in = addr;
    Data_in = wdata;
    @(posedge clk);
    @(negedge clk);
    CPU_MIO = 1'b0;
    mem_w   = 1'($urandom);
    Addr_in = $urandom;
    Data_in = $urandom;

    checks++;
    if (slv_addr !== addr[27:0] || slv_wdata !== wdata) begin
      failures++;
      $display("FAIL %s latch: slv_addr=%h slv_wdata=%h exp %h %h", name, slv_addr, slv_wdata,
               addr[27:0], wdata);
    end

    if (region == 4'hF && we) begin
      if (addr[27:0] == 28'h0) m_mask = wdata[NCH-1:0];
      else if (addr[27:0] == 28'h4) m_pend = m_pend & ~wdata[NCH-1:0];
    end
    drive_irq(irq_v);
    if (!we) m_dout = exp_rd;
    if (!mapped && region != 4'hF) m_err = 1'b1;

    lat = 0; sel_cyc = 0; we_cyc = 0; bad_sel = 0;
    for (int n = 2; n < 40; n++) begin
      if (n > 2) @(negedge clk);
      if (slv_sel !== '0) begin
        sel_cyc++;
        if (slv_sel !== exp_onehot) bad_sel++;
      end
      if (slv_we === 1'b1) we_cyc++;
      if (MIO_ready === 1'b1) begin
        lat = n;
        break;
      end
    end

    checks++;
    if (lat != exp_lat) begin
      failures++;
      $display("FAIL %s latency: got %0d exp %0d", name, lat, exp_lat);
    end
    checks++;
    if (sel_cyc != exp_sel || bad_sel != 0) begin
      failures++;
      $display("FAIL %s slv_sel: cycles %0d exp %0d, wrong-select cycles %0d", name, sel_cyc,
               exp_sel, bad_sel);
    end
    checks++;
    if (we_cyc != exp_we) begin
      failures++;
      $display("FAIL %s slv_we: cycles %0d exp %0d", name, we_cyc, exp_we);
    end
    checks++;
    if (Data_out !== m_dout) begin
      failures++;
      $display("FAIL %s Data_out: got %h exp %h", name, Data_out, m_dout);
    end
    checks++;
    if (bus_err !== m_err) begin
      failures++;
      $display("FAIL %s bus_err: got %b exp %b", name, bus_err, m_err);
    end

    @(negedge clk);
    checks++;
    if (MIO_ready !== 1'b0) begin
      failures++;
      $display("FAIL %s ready pulse: MIO_ready still %b", name, MIO_ready);
    end
    checks++;
    if (INT !== (|(m_pend & m_mask)) || int_id !== exp_id(m_pend & m_mask)) begin
      failures++;
      $display("FAIL %s irq: INT=%b int_id=%0d exp %b %0d", name, INT, int_id,
               |(m_pend & m_mask), exp_id(m_pend & m_mask));
    end
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    CPU_MIO   = 1'b0;
    mem_w     = 1'b0;
    Addr_in   = 32'h0;
    Data_in   = 32'h0;
    slv_rdata = '0;
    slv_irq   = '0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (Data_out !== 32'h0 || MIO_ready !== 1'b0 || INT !== 1'b0 || int_id !== 4'd0 ||
        bus_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_cpu_side: Data_out=%h MIO_ready=%b INT=%b int_id=%0d bus_err=%b",
               Data_out, MIO_ready, INT, int_id, bus_err);
    end
    checks++;
    if (slv_sel !== '0 || slv_we !== 1'b0 || slv_addr !== 28'h0 || slv_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_slave_side: sel=%b we=%b addr=%h wdata=%h", slv_sel, slv_we,
               slv_addr, slv_wdata);
    end
    reset = 1'b0;
  endtask

  task automatic test_read();
    slv_rdata = {32'h0BAD_0003, 32'h1234_5678, 32'h0BAD_0001, 32'h0BAD_0000};
    txn("read_ch2", 1'b0, 32'h2000_0010, 32'h0, '0);
    checks++;
    if (Data_out !== 32'h1234_5678) begin
      failures++;
      $display("FAIL read_ch2 value: got %h exp 12345678", Data_out);
    end
  endtask

  task automatic test_write();
    txn("write_ch1", 1'b1, 32'h1000_0004, 32'hA5A5_A5A5, '0);
    checks++;
    if (Data_out !== 32'h1234_5678) begin
      failures++;
      $display("FAIL write_keeps_dout: got %h exp 12345678", Data_out);
    end
  endtask

  task automatic test_unmapped();
    txn("unmapped_rd", 1'b0, 32'h7000_0000, 32'h0, '0);
    checks++;
    if (Data_out !== 32'hDEAD_BEEF || bus_err !== 1'b1) begin
      failures++;
      $display("FAIL unmapped_value: Data_out=%h bus_err=%b exp deadbeef 1", Data_out, bus_err);
    end
    txn("after_unmapped", 1'b0, 32'h0000_0100, 32'h0, '0);
  endtask

  task automatic test_interrupt();
    txn("mask_wr", 1'b1, 32'hF000_0000, 32'h0000_0006, '0);
    drive_irq(4'b0110);
    @(negedge clk);
    drive_irq(4'b0000);
    @(negedge clk);
    checks++;
    if (INT !== 1'b1 || int_id !== 4'd1) begin
      failures++;
      $display("FAIL irq_two_pending: INT=%b int_id=%0d exp 1 1", INT, int_id);
    end
    txn("w1c_bit1", 1'b1, 32'hF000_0004, 32'h0000_0002, '0);
    checks++;
    if (INT !== 1'b1 || int_id !== 4'd2) begin
      failures++;
      $display("FAIL irq_after_w1c1: INT=%b int_id=%0d exp 1 2", INT, int_id);
    end
    txn("w1c_bit2", 1'b1, 32'hF000_0004, 32'h0000_0004, '0);
    checks++;
    if (INT !== 1'b0 || int_id !== 4'd0) begin
      failures++;
      $display("FAIL irq_after_w1c2: INT=%b int_id=%0d exp 0 0", INT, int_id);
    end
  endtask

  task automatic test_collision();
    drive_irq(4'b1000);
    @(negedge clk);
    drive_irq(4'b0000);
    @(negedge clk);
    txn("w1c_collide", 1'b1, 32'hF000_0004, 32'h0000_0008, 4'b1000);
    txn("pend_rd", 1'b0, 32'hF000_0004, 32'h0, 4'b1000);
    checks++;
    if (Data_out[3] !== 1'b1) begin
      failures++;
      $display("FAIL collision_set_wins: pending=%h exp bit3 set", Data_out);
    end
    drive_irq(4'b0000);
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit ready_seen;
    CPU_MIO = 1'b1;
    mem_w   = 1'b0;
    Addr_in = 32'h0000_0020;
    @(posedge clk);
    @(negedge clk);
    CPU_MIO = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    #1;
    model_reset();
    checks++;
    if (slv_sel !== '0 || slv_we !== 1'b0 || Data_out !== 32'h0 || bus_err !== 1'b0 ||
        slv_addr !== 28'h0 || INT !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid_clear: sel=%b we=%b dout=%h err=%b addr=%h INT=%b", slv_sel,
               slv_we, Data_out, bus_err, slv_addr, INT);
    end
    ready_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (MIO_ready !== 1'b0) ready_seen = 1'b1;
    end
    checks++;
    if (ready_seen) begin
      failures++;
      $display("FAIL reset_mid_ready: MIO_ready pulsed during reset, exp none");
    end
    reset = 1'b0;
    slv_rdata[32 +: 32] = 32'hC0FF_EE01;
    txn("post_reset_rd", 1'b0, 32'h1000_0040, 32'h0, '0);
  endtask

  task automatic test_back_to_back();
    logic [31:0] addr;
    logic [3:0]  region;
    int          kind;
    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 5);
      if (kind <= 2) region = 4'($urandom_range(0, NCH - 1));
      else if (kind == 3) region = 4'hF;
      else region = 4'($urandom_range(NCH, 14));
      addr = {region, 28'($urandom)};
      if (region == 4'hF) addr[27:0] = 28'($urandom_range(0, 2) * 4);
      for (int k = 0; k < NCH; k++) slv_rdata[k*32 +: 32] = $urandom;
      txn("random", 1'($urandom), addr, $urandom, NCH'($urandom));
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_unmapped();
    test_interrupt();
    test_collision();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
